// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Defining SEQ_DIVIDER_FLUSH_EN adds a synchronous flush input that squashes the operation in flight.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SEQ_DIVIDER_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d, result_q, result_d;
  logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d, rem_q, rem_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             flush_i, a_neg, b_neg, ovf;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
`ifdef SEQ_DIVIDER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif
  always_comb begin
    a_neg    = ~op[0] & dividend[WIDTH-1];
    b_neg    = ~op[0] & divisor[WIDTH-1];
    a_mag    = a_neg ? -dividend : dividend;
    b_mag    = b_neg ? -divisor : divisor;
    ovf      = ~op[0] && dividend == {1'b1, {(WIDTH-1){1'b0}}} && &divisor;
    shifted  = {r_q, q_q[WIDTH-1]};
    trial    = shifted - {1'b0, d_q};
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    rem_d    = rem_q;
    result_d = result_q;
    busy_d   = done_q ? 1'b0 : busy_q;
    done_d   = 1'b0;
    if (state_q == IDLE && start && !busy_q) begin
      busy_d  = 1'b1;
      rem_d   = op[1];
      neg_q_d = 1'b0;
      neg_r_d = 1'b0;
      cnt_d   = '0;
      state_d = CALC;
      // Special cases skip iteration and land their final Q/R unsigned.
      if (divisor == '0) begin
        q_d     = '1;
        r_d     = dividend;
        state_d = DONE;
      end else if (ovf) begin
        q_d     = {1'b1, {(WIDTH-1){1'b0}}};
        r_d     = '0;
        state_d = DONE;
      end else begin
        q_d     = a_mag;
        r_d     = '0;
        d_d     = b_mag;
        neg_q_d = a_neg ^ b_neg;
        neg_r_d = a_neg;
      end
    end else if (state_q == CALC) begin
      q_d     = {q_q[WIDTH-2:0], ~trial[WIDTH]};
      r_d     = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CW'(WIDTH-1) ? DONE : CALC;
    end else if (state_q == DONE) begin
      result_d = rem_q ? (neg_r_q ? -r_q : r_q) : (neg_q_q ? -q_q : q_q);
      done_d   = 1'b1;
      state_d  = IDLE;
    end
    if (flush_i) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      rem_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic RV32M model.
module tb_seq_divider;
  logic        clk = 0, rst_n = 0, start = 0;
  logic [1:0]  op = 0;
  logic [31:0] dividend = 0, divisor = 0, result;
  logic        busy, done;
`ifdef SEQ_DIVIDER_FLUSH_EN
  logic        flush = 0;
`endif
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SEQ_DIVIDER_FLUSH_EN
    .flush(flush),
`endif
    .start(start), .op(op), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result)
  );
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return o[1] ? a : 32'hFFFFFFFF;
    if (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return o[1] ? 32'h0 : a;
    if (!o[0]) return o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return o[1] ? a % b : a / b;
  endfunction
  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 33;
  endfunction
  task automatic wait_idle();
    for (int i = 0; i < 100 && (busy || done); i++) @(posedge clk);
  endtask
  // lat: edges after the accepting edge until done is seen (-1 on timeout); bcnt: samples with busy=1 and done=0.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt);
    wait_idle();
    @(negedge clk);
    start = 1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 0; dividend = $urandom; divisor = $urandom;
    lat = -1; bcnt = (busy && !done) ? 1 : 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      if (busy) bcnt++;
    end
    res = result;
  endtask
  task automatic test_reset();
    rst_n = 0; #12;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result got=%h exp=0", result); else passed++;
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_divu();
    logic [31:0] r; int lat, bc;
    run_op(2'b01, 32'd100, 32'd7, r, lat, bc);
    checks++; if (r !== 32'd14) $display("FAIL divu_result got=%0d exp=14", r); else passed++;
    checks++; if (lat !== 33) $display("FAIL divu_latency got=%0d exp=33", lat); else passed++;
    checks++; if (bc !== 33) $display("FAIL divu_busy_cycles got=%0d exp=33", bc); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL divu_busy_at_done got=%b exp=1", busy); else passed++;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) $display("FAIL divu_done_pulse got=%b exp=0", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL divu_busy_fall got=%b exp=0", busy); else passed++;
    checks++; if (result !== 32'd14) $display("FAIL divu_result_hold got=%0d exp=14", result); else passed++;
  endtask
  task automatic test_signed();
    logic [31:0] r; int lat, bc;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, r, lat, bc);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL rem_neg got=%h exp=ffffffff", r); else passed++;
    run_op(2'b00, 32'hFFFFFFF9, 32'd2, r, lat, bc);
    checks++; if (r !== 32'hFFFFFFFD) $display("FAIL div_neg got=%h exp=fffffffd", r); else passed++;
    checks++; if (lat !== 33) $display("FAIL div_neg_latency got=%0d exp=33", lat); else passed++;
  endtask
  task automatic test_special();
    logic [31:0] r; int lat, bc;
    logic [1:0]  ops [4] = '{2'b00, 2'b11, 2'b00, 2'b10};
    logic [31:0] as  [4] = '{32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h0};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bc);
      checks++; if (r !== exp[i]) $display("FAIL special%0d_result got=%h exp=%h", i, r, exp[i]); else passed++;
      checks++; if (lat !== 1) $display("FAIL special%0d_latency got=%0d exp=1", i, lat); else passed++;
    end
  endtask
  task automatic test_random();
    logic [31:0] a, b, r; logic [1:0] o; int lat, bc, sel;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom); a = $urandom; b = $urandom; sel = $urandom_range(0, 7);
      if (sel == 0) b = 0;
      if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (sel == 2) b = $urandom_range(1, 20);
      if (sel == 3) b = -$urandom_range(1, 20);
      run_op(o, a, b, r, lat, bc);
      checks++; if (r !== model(o, a, b)) $display("FAIL rand%0d op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, r, model(o, a, b)); else passed++;
      checks++; if (lat !== model_lat(o, a, b)) $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, model_lat(o, a, b)); else passed++;
    end
  endtask
  task automatic test_busy_ignore();
    int lat = -1;
    wait_idle();
    @(negedge clk); start = 1; op = 2'b01; dividend = 32'd1000; divisor = 32'd9;
    @(posedge clk); #1; start = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i >= 3 && i <= 10) begin start = 1; op = 2'b00; dividend = 32'd77; divisor = 32'd3; end
      else start = 0;
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    start = 0;
    checks++; if (result !== 32'd111) $display("FAIL busy_ignore_result got=%0d exp=111", result); else passed++;
    checks++; if (lat !== 33) $display("FAIL busy_ignore_latency got=%0d exp=33", lat); else passed++;
  endtask
  task automatic test_back_to_back();
    logic [31:0] r; int lat, bc;
    run_op(2'b11, 32'd50, 32'd8, r, lat, bc);
    start = 1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1; start = 0;
    checks++; if (busy !== 1'b0) $display("FAIL start_on_done_busy got=%b exp=0", busy); else passed++;
    run_op(2'b01, 32'd9, 32'd3, r, lat, bc);
    checks++; if (r !== 32'd3) $display("FAIL back_to_back_result got=%0d exp=3", r); else passed++;
  endtask
  task automatic test_reset_mid();
    logic [31:0] r; int lat, bc;
    wait_idle();
    @(negedge clk); start = 1; op = 2'b01; dividend = 32'd500; divisor = 32'd5;
    @(posedge clk); #1; start = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0; #1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_mid_done got=%b exp=0", done); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL rst_mid_result got=%h exp=0", result); else passed++;
    @(negedge clk); rst_n = 1;
    run_op(2'b00, 32'hFFFFFF9C, 32'd7, r, lat, bc);
    checks++; if (r !== model(2'b00, 32'hFFFFFF9C, 32'd7)) $display("FAIL rst_mid_after got=%h exp=%h", r, model(2'b00, 32'hFFFFFF9C, 32'd7)); else passed++;
  endtask
`ifdef SEQ_DIVIDER_FLUSH_EN
  task automatic test_flush();
    logic [31:0] r, prev; int lat, bc, pulses = 0;
    wait_idle();
    prev = result;
    @(negedge clk); start = 1; op = 2'b01; dividend = 32'd12345; divisor = 32'd6;
    @(posedge clk); #1; start = 0;
    repeat (5) @(posedge clk);
    @(negedge clk); flush = 1; start = 1;
    @(posedge clk); #1; flush = 0; start = 0;
    checks++; if (busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy); else passed++;
    checks++; if (result !== prev) $display("FAIL flush_result got=%h exp=%h", result, prev); else passed++;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done || busy) pulses++; end
    checks++; if (pulses !== 0) $display("FAIL flush_no_done got=%0d exp=0", pulses); else passed++;
    run_op(2'b01, 32'hFFFFFFFF, 32'h10, r, lat, bc);
    checks++; if (r !== 32'h0FFFFFFF) $display("FAIL flush_after got=%h exp=0fffffff", r); else passed++;
  endtask
`endif
  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_special();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_DIVIDER_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
